// File: rtl/glay_axi4_slave_mem.sv
// glay_axi4_slave_mem: AXI4 memory responder for the 512-bit cache back-end ports.
// Line-addressed byte-enabled array with independent INCR read and write channels,
// one outstanding transaction per channel.
// Ports:
//   ap_clk, ap_rst_n        clock and asynchronous active-low reset
//   s_axi_aw*/w*/b*         write address, write data and write response channels
//   s_axi_ar*/r*            read address and read data channels
module glay_axi4_slave_mem #(
  parameter int unsigned AXI_ADDR_W  = 64,
  parameter int unsigned AXI_DATA_W  = 512,
  parameter int unsigned AXI_ID_W    = 1,
  parameter int unsigned MEM_DEPTH_W = 10
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic [2:0]              s_axi_awsize,
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic [2:0]              s_axi_arsize,
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic                    s_axi_rlast
);

  localparam int unsigned STRB_W   = AXI_DATA_W / 8;
  localparam int unsigned DEPTH    = 1 << MEM_DEPTH_W;
  localparam int unsigned LINE_LSB = 6;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  // Burst type and size are ignored; address bits outside the line index are don't-care.
  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awaddr, s_axi_araddr, s_axi_awburst, s_axi_arburst,
                         s_axi_awsize, s_axi_arsize};

  // Read response is always OKAY.
  assign s_axi_rresp = RESP_OKAY;

  // ---------------- write channel ----------------
  w_state_t               w_state;
  logic [MEM_DEPTH_W-1:0] w_idx;
  logic [7:0]             w_len;
  logic [7:0]             w_cnt;
  logic                   w_err;
  logic                   w_fire;
  logic                   w_at_end;
  logic                   wlast_bad;

  assign w_fire    = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_at_end  = (w_cnt == w_len);
  assign wlast_bad = (s_axi_wlast != w_at_end);

  // Write FSM; beat count, not wlast, decides the end of the burst.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            w_idx         <= s_axi_awaddr[MEM_DEPTH_W+LINE_LSB-1:LINE_LSB];
            w_len         <= s_axi_awlen;
            s_axi_bid     <= s_axi_awid;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_at_end) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_idx <= w_idx + MEM_DEPTH_W'(1);
              w_err <= w_err || wlast_bad;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array write port with per-byte enables; contents are not reset.
  always_ff @(posedge ap_clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t               r_state;
  logic [MEM_DEPTH_W-1:0] r_idx;
  logic [7:0]             r_len;
  logic [7:0]             r_cnt;
  logic                   r_done;
  logic                   sk_valid;
  logic [AXI_DATA_W-1:0]  sk_data;
  logic                   sk_last;
  logic [AXI_DATA_W-1:0]  rd_line;
  logic                   r_issue;
  logic                   r_issue_last;
  logic                   r_pop;

  // Array read port; captured into the output buffer at the issuing edge, so a
  // same-cycle write to the line is not yet visible (read-first).
  assign rd_line      = mem[r_idx];
  assign r_pop        = s_axi_rvalid && s_axi_rready;
  assign r_issue_last = (r_cnt == r_len);
  // Buffer is the output register plus one skid entry; only a full, stalled buffer blocks issue.
  assign r_issue      = (r_state == R_DATA) && !r_done && !(sk_valid && !s_axi_rready);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_last       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            r_idx         <= s_axi_araddr[MEM_DEPTH_W+LINE_LSB-1:LINE_LSB];
            r_len         <= s_axi_arlen;
            s_axi_rid     <= s_axi_arid;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_issue) begin
            if (r_issue_last) begin
              r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              r_idx <= r_idx + MEM_DEPTH_W'(1);
            end
          end
          // Output/skid buffer update: pop shifts skid forward, issue fills the first free slot.
          if (r_pop) begin
            if (sk_valid) begin
              s_axi_rdata <= sk_data;
              s_axi_rlast <= sk_last;
              sk_valid    <= r_issue;
              if (r_issue) begin
                sk_data <= rd_line;
                sk_last <= r_issue_last;
              end
            end else if (r_issue) begin
              s_axi_rdata <= rd_line;
              s_axi_rlast <= r_issue_last;
            end else begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end
          end else if (r_issue) begin
            if (!s_axi_rvalid) begin
              s_axi_rvalid <= 1'b1;
              s_axi_rdata  <= rd_line;
              s_axi_rlast  <= r_issue_last;
            end else begin
              sk_valid <= 1'b1;
              sk_data  <= rd_line;
              sk_last  <= r_issue_last;
            end
          end
          if (r_pop && s_axi_rlast) begin
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/glay_axi4_slave_mem.md
# glay_axi4_slave_mem

AXI4 memory responder (slave) that terminates the 512-bit read and write master ports driven by `glay_kernel_cu`'s cache back end. It holds a byte-enabled line-addressed memory array and serves INCR bursts on independent read and write channels. It is used as the memory endpoint in kernel-level simulation benches and as an on-chip scratch target.

## Interface
Parameters:
- `AXI_ADDR_W`, 64: AXI address width.
- `AXI_DATA_W`, 512: AXI data width; one beat is one 64-byte line.
- `AXI_ID_W`, 1: ID width; ID is echoed on responses.
- `MEM_DEPTH_W`, 10: log2 of the number of lines in the memory (1024 lines, 64 KiB).

Ports (ready/valid pairs follow AXI4 semantics):
- `ap_clk`  in  1  kernel clock; the only clock.
- `ap_rst_n`  in  1  asynchronous active-low reset.
- `s_axi_awvalid`/`awready`  in/out  1  write-address handshake.
- `s_axi_awaddr`  in  AXI_ADDR_W  byte address of the first beat.
- `s_axi_awlen`  in  8  burst length minus 1.
- `s_axi_awburst`  in  2  burst type.
- `s_axi_awsize`  in  3  beat size.
- `s_axi_awid`  in  AXI_ID_W  write ID.
- `s_axi_wvalid`/`wready`  in/out  1  write-data handshake.
- `s_axi_wdata`  in  AXI_DATA_W  write data.
- `s_axi_wstrb`  in  AXI_DATA_W/8  byte enables.
- `s_axi_wlast`  in  1  last write beat.
- `s_axi_bvalid`/`bready`  out/in  1  write-response handshake.
- `s_axi_bresp`  out  2  write response.
- `s_axi_bid`  out  AXI_ID_W  write response ID.
- `s_axi_arvalid`/`arready`  in/out  1  read-address handshake.
- `s_axi_araddr`, `arlen`, `arburst`, `arsize`, `arid`  in  as the AW fields  read request fields.
- `s_axi_rvalid`/`rready`  out/in  1  read-data handshake.
- `s_axi_rdata`  out  AXI_DATA_W  read data.
- `s_axi_rresp`  out  2  read response.
- `s_axi_rid`  out  AXI_ID_W  read ID.
- `s_axi_rlast`  out  1  last read beat.

## Operation
- **Memory.** Simple dual-port array: one read port and one write port. Line index is `addr[MEM_DEPTH_W+5:6]`. The lower 6 address bits are ignored. Higher address bits are ignored, so the address wraps modulo the array size.
- **Burst rules.**
  - All bursts are treated as INCR with full-width beats; `awburst`/`arburst`/`awsize`/`arsize` are ignored.
  - The line index increments by 1 per beat and wraps from 2^MEM_DEPTH_W-1 to 0.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: `awready`=1. On the AW handshake, latch index, len and ID, clear the beat counter, and go to W_DATA.
  - W_DATA: `wready`=1. Each W handshake writes the bytes whose `wstrb` bit is set; bytes with a clear strobe keep their old value.
  - W_DATA exit: when the beat count equals len, go to W_RESP.
  - wlast mismatch: if `wlast` differs from (count==len) on any beat, set a sticky error flag. Still exactly len+1 beats are consumed.
  - W_RESP: `bvalid`=1, `bid` = latched ID, `bresp` = 2'b10 (SLVERR) if the error flag is set, else 2'b00. On `bready`, return to W_IDLE.
- **Read FSM: R_IDLE → R_DATA → R_IDLE.**
  - R_IDLE: `arready`=1. On the AR handshake, latch index, len and ID, and go to R_DATA.
  - R_DATA: issue array reads into a 2-entry output buffer. Reads are issued only while the buffer has room, so no beat is ever dropped.
  - Outputs: `rresp`=2'b00 always; `rid` = latched ID; `rlast`=1 on beat len.
  - R_DATA exit: on the `rlast` handshake, return to R_IDLE.
- **Channel independence.** Read and write channels are fully independent and may be active in the same cycle.
- **Same-line collision.** If a read and a write hit the same line in the same cycle, the read returns the old data (read-first).
- **Outstanding transactions.** One outstanding transaction per channel. `awready`/`arready` are 0 outside the idle states.

## Timing
- **Reset.** While `ap_rst_n`=0, all outputs are 0: `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, `bresp`, `rresp`, `rdata`. Memory contents are not reset.
- **After reset.** `awready`/`arready` go to 1 in the first cycle after deassertion.
- **Reset mid-burst.** Asserting reset mid-burst aborts both FSMs to idle immediately. No response is issued for the aborted transaction.
- **Write path.**
  - AW handshake at cycle N → `wready`=1 at N+1.
  - The last W beat at cycle M → `bvalid`=1 at M+1.
  - The write is visible to a read issued at M+1 or later.
- **Read path.**
  - AR handshake at cycle N → first `rvalid` at N+2 (one cycle of address register, one cycle of array read).
  - With `rready` held at 1, one beat per cycle; a burst of len L completes at N+2+L.
- **Stability.** `rdata`/`rlast`/`rid` hold stable while `rvalid`=1 and `rready`=0. `bvalid` is held until `bready`.
- **Zero-length burst.** `awlen`/`arlen`=0 is a single beat with `wlast`/`rlast` on that beat.

## Test plan
- **Single write then read.** Write 1 beat to 0x0000_1000 with data 0xA5 repeated and all strobes set, then read 1 beat. Required: `bresp`=0, `rdata`=0xA5 repeated, `rlast`=1, first `rvalid` 2 cycles after the AR handshake.
- **Burst with backpressure.** Write a 16-beat burst (awlen=15) at 0x0 with beat i = i; read it back with `rready` toggling every cycle. Required: 16 beats in order 0..15, `rlast` only on beat 15, `rdata` stable on stalled cycles.
- **Partial strobes.** Write all-ones to line 3; then write line 3 with `wstrb`=0x0000_0000_0000_00FF and data 0. Required: readback has low 8 bytes 0x00 and the rest 0xFF.
- **Wrap-around.** With MEM_DEPTH_W=10, write a 4-beat burst at 0xFFC0 (line 1023). Required: data lands in lines 1023, 0, 1, 2; a read of address 0x1_0000 returns the line-0 data.
- **Protocol error and concurrency.** Send awlen=3 with `wlast` on beat 1 → `bresp`=2'b10 after exactly 4 beats. Concurrently run an 8-beat read with matching `arid`=1 → `rid`=1 and correct data, unaffected by the write.
- **Mid-burst reset.** Pull `ap_rst_n` low during beat 5 of a 16-beat read. Required: `rvalid`=0 immediately; after release, `arready`=1 on the next cycle and a new read completes normally.
